spi_flash_writer: RTL
=====================

Name: spi_flash_writer

Overview:
- Downstream stage of the acquisition arbiter. It consumes one write request at a time: a DATA_WIDTH data word plus a word address.
- For each request it runs a complete SPI NOR program sequence: WREN (0x06), PAGE PROGRAM (0x02) with a 3-byte address and the data bytes, then RDSR (0x05) status polling until WIP clears.
- It holds flash_write_ready low for the whole sequence, which back-pressures the arbiter.

Parameters:
- DATA_WIDTH, 16, request data width; must be a multiple of 8.
- ADDR_WIDTH, 24, request word-address width.
- CLK_DIV, 2, SCLK half-period in clk cycles (>=1); SCLK frequency = clk/(2*CLK_DIV).
- CS_GAP, 2, minimum clk cycles spi_cs_n stays high between transactions (>=1).
- POLL_LIMIT, 1024, maximum RDSR transactions per request before timeout.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- flash_write_start, input, 1, request strobe; sampled only while flash_write_ready=1.
- flash_write_data, input, DATA_WIDTH, word to program.
- flash_write_addr, input, ADDR_WIDTH, word address.
- flash_write_ready, output, 1, high when idle and able to accept a request.
- write_error, output, 1, one-cycle pulse on poll timeout.
- spi_sclk, output, 1, SPI clock, mode 0.
- spi_cs_n, output, 1, chip select, active low.
- spi_mosi, output, 1, serial data out, MSB first.
- spi_miso, input, 1, serial data in.

Behaviour:
- Reset values (asynchronous, also if reset is asserted mid-transfer):
  - flash_write_ready=1, write_error=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0.
  - FSM returns to IDLE; poll counter and shift registers clear.
  - No partial SPI frame continues after reset.
- Acceptance:
  - flash_write_start=1 while ready=1 latches data and addr on that edge.
  - flash_write_ready goes 0 on the next cycle and stays 0 until the return to IDLE.
  - start while ready=0 is ignored, with no queuing.
- Byte address = {flash_write_addr, 1'b0} truncated to 24 bits. Data is sent most-significant byte first.
- FSM states: IDLE -> WREN -> GAP_A -> PROG -> GAP_B -> POLL -> (WIP=1: GAP_C -> POLL | WIP=0: IDLE).
- Each SPI transaction (identical timing for all):
  - spi_cs_n falls.
  - spi_mosi is valid one half-period before the first rising edge of spi_sclk.
  - Each bit lasts 2*CLK_DIV cycles: spi_sclk low half, then high half.
  - MOSI changes only while spi_sclk is low; MISO is sampled on the clk edge where spi_sclk rises.
  - After the last bit, spi_sclk returns low, then spi_cs_n rises one half-period later.
- Transaction contents:
  - WREN: 8 bits, 0x06.
  - PROG: 0x02, address bytes [23:16],[15:8],[7:0], then DATA_WIDTH/8 data bytes. Total 32+DATA_WIDTH bits.
  - POLL: 0x05, then 8 bits read with MOSI=0. Status bit0 = WIP.
- GAP states hold spi_cs_n=1 and spi_sclk=0 for exactly CS_GAP cycles.
- Poll counter:
  - Increments once per completed POLL transaction.
  - If WIP=1 on poll number POLL_LIMIT: write_error=1 for one cycle, then return to IDLE (ready=1 on the following cycle); no retry.
- Return to IDLE after WIP=0: ready=1 on the cycle after spi_cs_n rises at the end of the final POLL.
- spi_miso is ignored outside the POLL read phase.

Test Plan:
- Reset idle:
  - Stimulus: hold rst_n=0, release.
  - Required response: ready=1, cs_n=1, sclk=0, mosi=0, write_error=0; no SCLK edges while idle.
- Basic program (CLK_DIV=2, DATA_WIDTH=16):
  - Stimulus: start with addr=0x000010, data=0xA55A; MISO returns status 0x00.
  - Required response on MOSI: 0x06, then 0x02 0x00 0x00 0x20 0xA5 0x5A, then 0x05.
  - Required timing: each bit 4 clks, each cs_n-high gap = 2 clks, ready returns to 1 after a single poll.
- Busy polling:
  - Stimulus: MISO returns status 0x01 for 3 polls, then 0x00.
  - Required response: exactly 4 RDSR transactions, then ready=1; write_error stays 0.
- Timeout (POLL_LIMIT=4):
  - Stimulus: MISO held at 1.
  - Required response: 4 polls, one write_error pulse, then ready=1 with no further SPI activity.
- Ignored start and address wrap:
  - Stimulus: pulse start during PROG, then issue a request with addr=0xFFFFFF.
  - Required response: the mid-PROG start has no effect; the second request's address bytes are 0xFF 0xFF 0xFE.
- Reset mid-PROG:
  - Stimulus: assert rst_n=0 during the 3rd address byte.
  - Required response: cs_n=1 and sclk=0 immediately (asynchronously), ready=1.
  - Follow-up: a new request afterwards starts cleanly with WREN.

Source files
------------

// File: rtl/spi_flash_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_flash_writer: WREN / PAGE PROGRAM / RDSR-poll sequencer (SPI mode 0)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_flash_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 24,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flash_write_start,
  input  logic [DATA_WIDTH-1:0] flash_write_data,
  input  logic [ADDR_WIDTH-1:0] flash_write_addr,
  output logic                  flash_write_ready,
  output logic                  write_error,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int SHW     = 32 + DATA_WIDTH;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(2 * SHW + 1);
  localparam int PW      = $clog2(POLL_LIMIT + 1);
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE, WREN, GAP_A, PROG, GAP_B, POLL, GAP_C, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]       half_q, half_d;
  logic [SHW-1:0]      shift_q, shift_d;
  logic [SHW-9:0]      payload_q, payload_d;
  logic [PW-1:0]       poll_cnt_q, poll_cnt_d;
  logic                wip_q, wip_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                err_q, err_d;

  logic [23:0]         w_byte_addr;
  logic                w_half_end;
  logic                w_gap_end;
  logic [HW-1:0]       w_last_half;

  // Word address -> byte address, truncated/extended to the 24-bit flash space.
  generate
    if (ADDR_WIDTH >= 24) begin : g_addr_trunc
      logic w_unused_addr;
      assign w_byte_addr   = {flash_write_addr[22:0], 1'b0};
      assign w_unused_addr = &{1'b0, flash_write_addr[ADDR_WIDTH-1:23]};
    end else if (ADDR_WIDTH == 23) begin : g_addr_exact
      assign w_byte_addr = {flash_write_addr, 1'b0};
    end else begin : g_addr_ext
      assign w_byte_addr = {{(23 - ADDR_WIDTH){1'b0}}, flash_write_addr, 1'b0};
    end
  endgenerate

  assign w_half_end  = (cnt_q == CW'(CLK_DIV - 1));
  assign w_gap_end   = (cnt_q == CW'(CS_GAP - 1));
  assign w_last_half = (state_q == WREN) ? HW'(16) :
                       (state_q == PROG) ? HW'(2 * SHW) : HW'(32);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    shift_d    = shift_q;
    payload_d  = payload_q;
    poll_cnt_d = poll_cnt_q;
    wip_d      = wip_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flash_write_start) begin
          payload_d  = {w_byte_addr, flash_write_data};
          shift_d    = {CMD_WREN, {(SHW-8){1'b0}}};
          cnt_d      = '0;
          half_d     = '0;
          poll_cnt_d = '0;
          cs_n_d     = 1'b0;
          state_d    = WREN;
        end
      end
      WREN, PROG, POLL: begin
        if (!w_half_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (half_q == w_last_half) begin
            // Trailing low half done: release CS and pick the follow-up state.
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            half_d = '0;
            case (state_q)
              WREN:    state_d = GAP_A;
              PROG:    state_d = GAP_B;
              default: begin
                poll_cnt_d = poll_cnt_q + 1'b1;
                if (!wip_q) begin
                  state_d = DONE;
                end else if (poll_cnt_q == PW'(POLL_LIMIT - 1)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
                end else begin
                  state_d = GAP_C;
                end
              end
            endcase
          end else begin
            half_d = half_q + 1'b1;
            sclk_d = ~half_q[0];
            if (half_q[0]) begin
              shift_d = shift_q << 1;
            end else if (state_q == POLL && half_q >= HW'(16)) begin
              wip_d = spi_miso;
            end
          end
        end
      end
      GAP_A, GAP_B, GAP_C: begin
        if (w_gap_end) begin
          cnt_d  = '0;
          half_d = '0;
          cs_n_d = 1'b0;
          if (state_q == GAP_A) begin
            shift_d = {CMD_PP, payload_q};
            state_d = PROG;
          end else begin
            shift_d = {CMD_RDSR, {(SHW-8){1'b0}}};
            state_d = POLL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      shift_q    <= '0;
      payload_q  <= '0;
      poll_cnt_q <= '0;
      wip_q      <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      shift_q    <= shift_d;
      payload_q  <= payload_d;
      poll_cnt_q <= poll_cnt_d;
      wip_q      <= wip_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      err_q      <= err_d;
    end
  end

  assign flash_write_ready = (state_q == IDLE);
  assign write_error       = err_q;
  assign spi_sclk          = sclk_q;
  assign spi_cs_n          = cs_n_q;
  assign spi_mosi          = shift_q[SHW-1];

endmodule
`default_nettype wire
